// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Function : Execute-stage ALU with RV32I R-type decode, an iterative MUL
//            (low word) and a registered valid/ready result stage.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [3:0]      func,
    input  logic            mext,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [4:0]      rd_out,
    output logic            busy
);

    localparam int ITERS = XLEN / MUL_BITS;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int SHW   = $clog2(XLEN);

    localparam logic [0:0]    C_ST_IDLE = 1'b0;
    localparam logic [0:0]    C_ST_MUL  = 1'b1;
    localparam logic [CW-1:0] C_ITERS   = CW'(ITERS);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    logic [0:0]      state_q,     state_d;
    logic [XLEN-1:0] acc_q,       acc_d;
    logic [XLEN-1:0] mcand_q,     mcand_d;
    logic [XLEN-1:0] mplier_q,    mplier_d;
    logic [CW-1:0]   count_q,     count_d;
    logic [4:0]      mul_rd_q,    mul_rd_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic            zero_q,      zero_d;
    logic            illegal_q,   illegal_d;
    logic [4:0]      rd_out_q,    rd_out_d;

    logic [XLEN-1:0] w_alu_res;
    logic            w_illegal;
    logic            w_is_mul;
    logic [SHW-1:0]  w_shamt;
    logic            w_accept;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mpl_digit;
    logic [XLEN-1:0] w_acc_next;

    assign w_shamt     = op_b[SHW-1:0];
    assign w_accept    = in_valid && in_ready;
    assign w_mul_done  = (state_q == C_ST_MUL) && (count_q == C_ONE);
    assign w_mpl_digit = XLEN'(mplier_q[MUL_BITS-1:0]);
    assign w_acc_next  = acc_q + mcand_q * w_mpl_digit;

    always_comb begin
        w_alu_res = '0;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        case (alu_op)
            2'b00: w_alu_res = op_a + op_b;
            2'b01: w_alu_res = op_a - op_b;
            2'b10: begin
                if (mext) begin
                    if (func[2:0] == 3'b000) w_is_mul  = 1'b1;
                    else                     w_illegal = 1'b1;
                end else begin
                    case (func)
                        4'b0000: w_alu_res = op_a + op_b;
                        4'b1000: w_alu_res = op_a - op_b;
                        4'b0001: w_alu_res = op_a << w_shamt;
                        4'b0010: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                        4'b0011: w_alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
                        4'b0100: w_alu_res = op_a ^ op_b;
                        4'b0101: w_alu_res = op_a >> w_shamt;
                        4'b1101: w_alu_res = $unsigned($signed(op_a) >>> w_shamt);
                        4'b0110: w_alu_res = op_a | op_b;
                        4'b0111: w_alu_res = op_a & op_b;
                        default: w_illegal = 1'b1;
                    endcase
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= C_ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = C_ST_IDLE;
        end else begin
            case (state_q)
                C_ST_IDLE: if (w_accept && w_is_mul) state_d = C_ST_MUL;
                C_ST_MUL:  if (w_mul_done)           state_d = C_ST_IDLE;
                default:                             state_d = C_ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy     = (state_q == C_ST_MUL);
        in_ready = (state_q == C_ST_IDLE) && (!out_valid_q || out_ready) && !flush;
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        mul_rd_d = mul_rd_q;
        if (w_accept && w_is_mul) begin
            acc_d    = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            count_d  = C_ITERS;
            mul_rd_d = rd_in;
        end else if ((state_q == C_ST_MUL) && !flush) begin
            acc_d    = w_acc_next;
            mcand_d  = mcand_q << MUL_BITS;
            mplier_d = mplier_q >> MUL_BITS;
            count_d  = count_q - C_ONE;
        end
    end

    // The result stage is free whenever MUL completes, so no arbitration is needed.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        rd_out_d    = rd_out_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept && !w_is_mul) begin
            out_valid_d = 1'b1;
            result_d    = w_alu_res;
            zero_d      = !w_illegal && (w_alu_res == '0);
            illegal_d   = w_illegal;
            rd_out_d    = rd_in;
        end else if (w_mul_done) begin
            out_valid_d = 1'b1;
            result_d    = w_acc_next;
            zero_d      = (w_acc_next == '0);
            illegal_d   = 1'b0;
            rd_out_d    = mul_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
            mul_rd_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            rd_out_q    <= '0;
        end else begin
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            count_q     <= count_d;
            mul_rd_q    <= mul_rd_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            rd_out_q    <= rd_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign rd_out    = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Function : Scoreboard bench for alu_exec_unit (XLEN=32, MUL_BITS=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [3:0]  func;
    logic        mext;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [4:0]  rd_out;
    logic        busy;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit #(.XLEN(32), .MUL_BITS(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .func      (func),
        .mext      (mext),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [3:0] f, input logic m,
                                   input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        e.res = 32'h0;
        e.ill = 1'b0;
        e.rd  = rd;
        case (op)
            2'd0: e.res = a + b;
            2'd1: e.res = a - b;
            2'd2: begin
                if (m) begin
                    if (f[2:0] == 3'd0) e.res = a * b;
                    else                e.ill = 1'b1;
                end else begin
                    case (f)
                        4'h0: e.res = a + b;
                        4'h8: e.res = a - b;
                        4'h1: e.res = a << b[4:0];
                        4'h2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        4'h3: e.res = (a < b) ? 32'd1 : 32'd0;
                        4'h4: e.res = a ^ b;
                        4'h5: e.res = a >> b[4:0];
                        4'hD: e.res = $unsigned($signed(a) >>> b[4:0]);
                        4'h6: e.res = a | b;
                        4'h7: e.res = a & b;
                        default: e.ill = 1'b1;
                    endcase
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.z = !e.ill && (e.res == 32'h0);
        return e;
    endfunction

    // Called just after an edge with inputs set; scores the coming edge.
    task automatic tick();
        exp_t e;
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_underflow", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    check("sb_result",  result,  e.res);
                    check("sb_zero",    zero,    e.z);
                    check("sb_illegal", illegal, e.ill);
                    check("sb_rd",      rd_out,  e.rd);
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(alu_op, func, mext, op_a, op_b, rd_in));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] f, input logic m,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = 1'b1;
        alu_op   = op;
        func     = f;
        mext     = m;
        op_a     = a;
        op_b     = b;
        rd_in    = rd;
    endtask

    // Waits for out_valid; bad flags any cycle without busy=1/in_ready=0.
    task automatic wait_result(output int n, output logic bad);
        n   = 0;
        bad = 1'b0;
        while (!out_valid && n < 100) begin
            if (!busy || in_ready) bad = 1'b1;
            tick();
            n++;
        end
        if (!out_valid) check("timeout", out_valid, 1);
    endtask

    initial begin
        int   n;
        logic bad;
        logic seen;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'd0; func = 4'd0; mext = 1'b0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result",    result,    0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_busy",      busy,      0);
        check("rst_rd_out",    rd_out,    0);
        @(posedge clk); #1;

        // back-to-back single-cycle ops
        drive(2'b00, 4'h0, 1'b0, 32'd5, 32'd7, 5'd1);               tick();
        check("add_valid", out_valid, 1);
        check("add_res",   result,    32'd12);
        check("add_zero",  zero,      0);
        drive(2'b10, 4'h8, 1'b0, 32'd7, 32'd7, 5'd2);               tick();
        check("sub_res",   result,    32'd0);
        check("sub_zero",  zero,      1);
        drive(2'b10, 4'hD, 1'b0, 32'h8000_0000, 32'd4, 5'd3);       tick();
        check("sra_res",   result,    32'hF800_0000);
        drive(2'b10, 4'h2, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd4);       tick();
        check("slt_res",   result,    32'd1);
        drive(2'b10, 4'h3, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd5);       tick();
        check("sltu_res",  result,    32'd0);
        drive(2'b10, 4'h1, 1'b0, 32'd1, 32'd33, 5'd6);              tick();
        check("sll_res",   result,    32'd2);
        drive(2'b11, 4'h0, 1'b0, 32'd9, 32'd9, 5'd7);               tick();
        check("ill_flag",  illegal,   1);
        check("ill_res",   result,    32'd0);
        check("ill_zero",  zero,      0);
        drive(2'b10, 4'h9, 1'b0, 32'd1, 32'd2, 5'd8);               tick();
        check("ill_func",  illegal,   1);
        in_valid = 1'b0;                                            tick();

        // MUL latency with a held follower
        drive(2'b10, 4'h0, 1'b1, 32'h0001_0003, 32'd5, 5'd9);       tick();
        drive(2'b00, 4'h0, 1'b0, 32'd3, 32'd4, 5'd10);
        wait_result(n, bad);
        check("mul_latency", n,       32);
        check("mul_busy",    bad,     0);
        check("mul_res",     result,  32'h0005_000F);
        check("mul_rd",      rd_out,  5'd9);
        check("mul_done_busy", busy,  0);
        tick();
        check("held_add",    result,  32'd7);
        in_valid = 1'b0;                                            tick();

        drive(2'b10, 4'h8, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11); tick();
        in_valid = 1'b0;
        wait_result(n, bad);
        check("mul_ff_res",  result,  32'd1);
        tick();

        // backpressure
        drive(2'b00, 4'h0, 1'b0, 32'd1, 32'd1, 5'd12);              tick();
        out_ready = 1'b0;
        drive(2'b10, 4'h4, 1'b0, 32'h0F0, 32'h0FF, 5'd13);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_res",   result,    32'd2);
            check("bp_ready", in_ready,  0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release", in_ready, 1);
        tick();
        check("bp_next_res", result, 32'h00F);
        in_valid = 1'b0;                                            tick();

        // flush on MUL iteration 10
        drive(2'b10, 4'h0, 1'b1, 32'd3, 32'd5, 5'd14);              tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("pre_flush_busy", busy, 1);
        flush = 1'b1;                                               tick();
        flush = 1'b0;
        check("flush_busy",  busy,      0);
        check("flush_valid", out_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("flush_no_result", seen, 0);

        // asynchronous reset mid-MUL
        drive(2'b10, 4'h0, 1'b1, 32'd3, 32'd5, 5'd15);              tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy",   busy,      0);
        check("arst_valid",  out_valid, 0);
        check("arst_result", result,    0);
        check("arst_rd",     rd_out,    0);
        check("arst_ready",  in_ready,  1);
        q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("sb_leftover", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute-stage ALU that decodes ALUOp/func, executes the operation and registers the result at the EX/MEM boundary with a valid/ready handshake.
- Adds full RV32I R-type decode, signed/unsigned compare, shifts, and an iterative multi-cycle MUL (M-extension low word).
- Sits between the ID/EX pipeline register and EX/MEM. Drives a busy/stall indication to the hazard unit.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- MUL_BITS, 1, multiplier bits retired per MUL iteration; must divide XLEN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts operation this cycle.
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 reserved.
- func  in  4  {funct7[5], funct3}.
- mext  in  1  funct7[0] (M-extension select).
- op_a  in  XLEN  operand A.
- op_b  in  XLEN  operand B.
- rd_in  in  5  destination register tag.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream consumes result.
- result  out  XLEN  registered result.
- zero  out  1  registered (result == 0).
- illegal  out  1  registered undecodable-operation flag.
- rd_out  out  5  registered destination tag.
- busy  out  1  MUL iteration in progress.

Behaviour:
- Clock and reset: clk is the single clock. rst_n is asynchronous and active-low. Reset forces the state to IDLE, out_valid/result/zero/illegal/rd_out to 0, and the MUL accumulator, operand and counter registers to 0.
- Decode by alu_op:
  - alu_op 00: ADD.
  - alu_op 01: SUB.
  - alu_op 11: illegal.
  - alu_op 10 with mext=0, by func: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND. Any other func is illegal.
  - alu_op 10 with mext=1: func[2:0]=000 is MUL. Anything else is illegal.
- Arithmetic rules:
  - ADD/SUB/MUL wrap modulo 2^XLEN.
  - Shift amount is op_b[log2(XLEN)-1:0].
  - SLT/SLTU produce 0 or 1, zero-extended.
- Illegal operations complete in one cycle with result=0, illegal=1 and zero=0.
- zero = (result == 0) for legal operations.
- Accept rule: accept = in_valid && in_ready && !flush. in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. When in_ready=0, in_valid is ignored and upstream holds its inputs.
- States:
  - IDLE. On accept of a single-cycle operation, the output register loads result/zero/illegal/rd_out and out_valid=1 on that same edge (latency 1). On accept of MUL, the unit loads multiplicand=op_a, multiplier=op_b, acc=0, count=XLEN/MUL_BITS and rd tag, then moves to MUL.
  - MUL. Each cycle: acc += multiplicand * multiplier[MUL_BITS-1:0]; multiplicand <<= MUL_BITS; multiplier >>= MUL_BITS; count--.
    - On the edge where count goes 1->0, the final acc loads into result with out_valid=1 and the state returns to IDLE.
    - MUL latency is XLEN/MUL_BITS edges after accept (32 for defaults). busy = (state==MUL).
- Output hold: out_valid and the result fields hold stable until an edge with out_ready=1. On that edge out_valid clears, unless a new single-cycle accept reloads the register in the same cycle (back-to-back, one op per clock).
- The output register is always free on MUL completion, because accept required it to be free or draining and nothing else writes it during MUL.
- Flush has priority over everything. On an edge with flush=1: out_valid is cleared, MUL is aborted to IDLE, and no accept occurs. result/rd_out may keep stale values.
- Reset asserted mid-MUL aborts immediately (asynchronous) to the reset state.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset and idle: reset then release with in_valid=0 -> out_valid=0, result=0, in_ready=1, busy=0.
- Back-to-back single-cycle ops with out_ready=1:
  - ADD 5+7 -> result=12, zero=0, out_valid one edge after accept.
  - Next cycle SUB 7-7 -> result=0, zero=1.
  - Next cycle SRA 0x80000000 by 4 -> 0xF8000000.
- Compare, shift and illegal decode:
  - SLT 0xFFFFFFFF, 1 -> 1; SLTU same operands -> 0.
  - SLL 1 by 33 -> 2 (shift amount masked to 1).
  - alu_op=11 -> illegal=1, result=0, zero=0.
- MUL latency and stall:
  - MUL 0x0001_0003 * 0x0000_0005 -> result 0x0005_000F exactly 32 edges after accept, busy=1 throughout.
  - in_ready=0 during MUL; a second in_valid is held and accepted only after completion.
  - MUL 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000001.
- Backpressure: out_ready=0 after ADD 1+1 -> result=2 held and in_ready=0 for 3 cycles. Raising out_ready drains it and the held op is accepted on the same edge.
- Flush and reset: flush on MUL iteration 10 -> busy=0 and out_valid=0 next edge, no result produced. rst_n low mid-MUL -> all outputs 0 immediately, without waiting for a clock edge.
